sprite_cmd_sequencer: RTL and testbench

Parametrised front end for sprite_command_controller.
- Collects 80-bit sprite commands from NUM_CH independent sources (key decoder, CPU, test pattern) using round-robin arbitration.
- Buffers them in a DEPTH-entry FIFO.
- Issues them one at a time as single-cycle write_cmd pulses, only when the controller reports not busy.
- Replaces the one-shot, unbuffered key-to-command path used on the FPGA bring-up board.

---
 rtl/sprite_cmd_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_sprite_cmd_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_cmd_sequencer.sv
// sprite_cmd_sequencer
//   Front end for sprite_command_controller. It collects sprite commands from
//   NUM_CH sources using round-robin arbitration and buffers them in a
//   DEPTH-entry FIFO. Commands go out one at a time as single-cycle write_cmd
//   strobes, and only while the controller reports not busy. NOP commands
//   (opcode 0) are dropped at the FIFO head without being issued.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   in_valid     per-channel command valid
//   in_cmd       per-channel command, channel i at [i*CMD_W +: CMD_W]
//   in_ready     per-channel accept, one-hot or zero
//   ctrl_busy    controller busy; sampled only while idle
//   write_cmd    single-cycle command strobe
//   cmd_out      command presented with write_cmd (held between strobes)
//   fifo_count   entries held; fifo_empty / fifo_full flags
//
// Optional build macro SPRITE_SEQ_STATS_EN adds the following:
//   stats_clr    synchronous clear of all statistics counters
//   issued_cnt   issued commands, nop_cnt dropped NOPs,
//   stall_cnt    idle cycles spent waiting on ctrl_busy with work queued
//   All three counters are 16 bits wide and saturate at their maximum value.

module sprite_cmd_sequencer #(
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 8,
    parameter int CMD_W      = 80,
    parameter int SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*CMD_W-1:0]    in_cmd,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic                       ctrl_busy,
    output logic                       write_cmd,
    output logic [CMD_W-1:0]           cmd_out,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fifo_empty,
`ifdef SPRITE_SEQ_STATS_EN
    output logic                       fifo_full,
    input  logic                       stats_clr,
    output logic [15:0]                issued_cnt,
    output logic [15:0]                nop_cnt,
    output logic [15:0]                stall_cnt
`else
    output logic                       fifo_full
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  rr_next;
    logic [NUM_CH-1:0] grant;
    logic             push;
    logic [CMD_W-1:0] push_data;

    // The outer loop walks the search order starting at rr_ptr. The inner
    // loop compares against every channel, so the in_valid index is always
    // a constant.
    always_comb begin
        grant   = '0;
        push    = 1'b0;
        rr_next = rr_ptr;
        if (!fifo_full) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (!push && (i == (32'(rr_ptr) + k) % NUM_CH) && in_valid[i]) begin
                        push     = 1'b1;
                        grant[i] = 1'b1;
                        rr_next  = CH_W'((i + 1) % NUM_CH);
                    end
                end
            end
        end
    end

    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                push_data = in_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    assign in_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic [CMD_W-1:0] head;
    logic [2:0]       head_op;

    assign head       = mem[rd_ptr];
    assign head_op    = head[CMD_W-1 -: 3];
    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue sequencer
    // ------------------------------------------------------------------
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             issue;
    logic             nop_pop;
    logic             stall;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        issue    = 1'b0;
        nop_pop  = 1'b0;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && head_op == 3'd0) begin
                    // NOPs drain at one per cycle even while the controller is busy.
                    pop     = 1'b1;
                    nop_pop = 1'b1;
                end else if (!fifo_empty && !ctrl_busy) begin
                    pop      = 1'b1;
                    issue    = 1'b1;
                    state_nx = SETTLE;
                    cnt_nx   = CNT_W'(SETTLE_CYC - 1);
                end else if (!fifo_empty) begin
                    stall = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            write_cmd <= 1'b0;
            cmd_out   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            write_cmd <= issue;
            if (issue) begin
                cmd_out <= head;
            end
        end
    end

`ifdef SPRITE_SEQ_STATS_EN
    // ------------------------------------------------------------------
    // Statistics; clear takes priority over a same-cycle increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            issued_cnt <= '0;
            nop_cnt    <= '0;
            stall_cnt  <= '0;
        end else begin
            if (issue   && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
            if (nop_pop && nop_cnt    != '1) nop_cnt    <= nop_cnt + 1'b1;
            if (stall   && stall_cnt  != '1) stall_cnt  <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall | nop_pop;
`endif

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Directed self-checking bench for sprite_cmd_sequencer with default parameters
// (NUM_CH=2, DEPTH=8, CMD_W=80, SETTLE_CYC=2). Inputs change 1 time unit
// after each rising edge, and outputs are sampled at that same point.

module tb_sprite_cmd_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   in_valid;
    logic [79:0]  ch0_cmd, ch1_cmd;
    logic [159:0] in_cmd;
    logic [1:0]   in_ready;
    logic         ctrl_busy;
    logic         write_cmd;
    logic [79:0]  cmd_out;
    logic [3:0]   fifo_count;
    logic         fifo_empty;
    logic         fifo_full;
`ifdef SPRITE_SEQ_STATS_EN
    logic         stats_clr;
    logic [15:0]  issued_cnt, nop_cnt, stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    assign in_cmd = {ch1_cmd, ch0_cmd};

    always #5 clk = ~clk;

    sprite_cmd_sequencer #(
        .NUM_CH(2),
        .DEPTH(8),
        .CMD_W(80),
        .SETTLE_CYC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_cmd(in_cmd),
        .in_ready(in_ready),
        .ctrl_busy(ctrl_busy),
        .write_cmd(write_cmd),
        .cmd_out(cmd_out),
        .fifo_count(fifo_count),
        .fifo_empty(fifo_empty),
`ifdef SPRITE_SEQ_STATS_EN
        .fifo_full(fifo_full),
        .stats_clr(stats_clr),
        .issued_cnt(issued_cnt),
        .nop_cnt(nop_cnt),
        .stall_cnt(stall_cnt)
`else
        .fifo_full(fifo_full)
`endif
    );

    function automatic logic [79:0] mk(input logic [2:0] op, input logic [15:0] tag);
        return {op, 61'd0, tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 2'b00;
        ch0_cmd   = '0;
        ch1_cmd   = '0;
        ctrl_busy = 1'b0;
`ifdef SPRITE_SEQ_STATS_EN
        stats_clr = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_write_cmd", 80'(write_cmd), 80'd0);
        check("rst_cmd_out", cmd_out, 80'd0);
        check("rst_count", 80'(fifo_count), 80'd0);
        check("rst_empty", 80'(fifo_empty), 80'd1);
        check("rst_full", 80'(fifo_full), 80'd0);
        check("rst_in_ready", 80'(in_ready), 80'd0);
        rst = 1'b0;

        // Round robin with both channels valid: A0, B0, A1, B1
        in_valid = 2'b11;
        ch0_cmd  = mk(3'd1, 16'hA0);
        ch1_cmd  = mk(3'd2, 16'hB0);
        #1;
        check("rr_grant0", 80'(in_ready), 80'b01);
        tick();                                   // push A0
        ch0_cmd = mk(3'd1, 16'hA1);
        #1;
        check("rr_grant1", 80'(in_ready), 80'b10);
        check("rr_wc_e1", 80'(write_cmd), 80'd0);
        check("rr_cnt_e1", 80'(fifo_count), 80'd1);
        tick();                                   // push B0, issue A0
        check("rr_wc_e2", 80'(write_cmd), 80'd1);
        check("rr_out_A0", cmd_out, mk(3'd1, 16'hA0));
        check("rr_cnt_e2", 80'(fifo_count), 80'd1);
        ch1_cmd = mk(3'd2, 16'hB1);
        #1;
        check("rr_grant2", 80'(in_ready), 80'b01);
        tick();                                   // push A1
        check("rr_wc_e3", 80'(write_cmd), 80'd0);
        check("rr_grant3", 80'(in_ready), 80'b10);
        tick();                                   // push B1
        in_valid = 2'b00;
        check("rr_wc_e4", 80'(write_cmd), 80'd0);
        check("rr_cnt_e4", 80'(fifo_count), 80'd3);
        tick();                                   // issue B0
        check("rr_wc_e5", 80'(write_cmd), 80'd1);
        check("rr_out_B0", cmd_out, mk(3'd2, 16'hB0));
        tick();
        check("rr_wc_e6", 80'(write_cmd), 80'd0);
        check("rr_hold_e6", cmd_out, mk(3'd2, 16'hB0));
        tick();
        check("rr_wc_e7", 80'(write_cmd), 80'd0);
        tick();                                   // issue A1
        check("rr_wc_e8", 80'(write_cmd), 80'd1);
        check("rr_out_A1", cmd_out, mk(3'd1, 16'hA1));
        check("rr_cnt_e8", 80'(fifo_count), 80'd1);
        tick();
        check("rr_wc_e9", 80'(write_cmd), 80'd0);
        tick();
        check("rr_wc_e10", 80'(write_cmd), 80'd0);
        tick();                                   // issue B1
        check("rr_wc_e11", 80'(write_cmd), 80'd1);
        check("rr_out_B1", cmd_out, mk(3'd2, 16'hB1));
        check("rr_empty_e11", 80'(fifo_empty), 80'd1);
        tick();
        tick();
        tick();

        // Fill to full while busy, then drain in order
        ctrl_busy = 1'b1;
        in_valid  = 2'b01;
        for (int k = 0; k < 8; k++) begin
            ch0_cmd = mk(3'(k % 7 + 1), 16'(16'h10 + k));
            tick();
        end
        check("full_count", 80'(fifo_count), 80'd8);
        check("full_flag", 80'(fifo_full), 80'd1);
        check("full_in_ready", 80'(in_ready), 80'd0);
        check("full_no_wc", 80'(write_cmd), 80'd0);
        tick();
        check("full_count_hold", 80'(fifo_count), 80'd8);
        check("full_no_wc2", 80'(write_cmd), 80'd0);
        in_valid  = 2'b00;
        ctrl_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("drain_wc", 80'(write_cmd), 80'd1);
            check("drain_out", cmd_out, mk(3'(k % 7 + 1), 16'(16'h10 + k)));
            check("drain_count", 80'(fifo_count), 80'(7 - k));
            tick();
            check("drain_gap1", 80'(write_cmd), 80'd0);
            tick();
            check("drain_gap2", 80'(write_cmd), 80'd0);
        end
        check("drain_empty", 80'(fifo_empty), 80'd1);
        tick();
`ifdef SPRITE_SEQ_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
`endif

        // NOP, op=1, NOP
        in_valid = 2'b01;
        ch0_cmd  = mk(3'd0, 16'h0E01);
        tick();                                   // push N1
        ch0_cmd = mk(3'd1, 16'h0C01);
        check("nop_wc_e1", 80'(write_cmd), 80'd0);
        check("nop_cnt_e1", 80'(fifo_count), 80'd1);
        tick();                                   // push C, pop N1
        ch0_cmd = mk(3'd0, 16'h0E02);
        check("nop_wc_e2", 80'(write_cmd), 80'd0);
        check("nop_cnt_e2", 80'(fifo_count), 80'd1);
        tick();                                   // push N2, issue C
        in_valid = 2'b00;
        check("nop_wc_e3", 80'(write_cmd), 80'd1);
        check("nop_out_C", cmd_out, mk(3'd1, 16'h0C01));
        check("nop_cnt_e3", 80'(fifo_count), 80'd1);
        tick();
        check("nop_wc_e4", 80'(write_cmd), 80'd0);
        tick();
        check("nop_wc_e5", 80'(write_cmd), 80'd0);
        check("nop_cnt_e5", 80'(fifo_count), 80'd1);
        tick();                                   // pop N2
        check("nop_wc_e6", 80'(write_cmd), 80'd0);
        check("nop_empty_e6", 80'(fifo_empty), 80'd1);
        check("nop_hold_out", cmd_out, mk(3'd1, 16'h0C01));
`ifdef SPRITE_SEQ_STATS_EN
        check("stat_nop", 80'(nop_cnt), 80'd2);
        check("stat_issued", 80'(issued_cnt), 80'd1);
        check("stat_stall0", 80'(stall_cnt), 80'd0);
`endif
        tick();

        // Simultaneous push/pop at count 4, then reset during SETTLE
        ctrl_busy = 1'b1;
        in_valid  = 2'b01;
        for (int k = 0; k < 4; k++) begin
            ch0_cmd = mk(3'd5, 16'(16'h50 + k));
            tick();
        end
        check("pp_count4", 80'(fifo_count), 80'd4);
        ctrl_busy = 1'b0;
        ch0_cmd   = mk(3'd5, 16'h54);
        tick();                                   // push + pop
        in_valid = 2'b00;
        check("pp_count_hold", 80'(fifo_count), 80'd4);
        check("pp_wc", 80'(write_cmd), 80'd1);
        check("pp_out", cmd_out, mk(3'd5, 16'h50));
        tick();
        tick();
        tick();                                   // second issue
        check("pp_wc2", 80'(write_cmd), 80'd1);
        check("pp_out2", cmd_out, mk(3'd5, 16'h51));
        check("pp_count3", 80'(fifo_count), 80'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_count", 80'(fifo_count), 80'd0);
        check("mrst_wc", 80'(write_cmd), 80'd0);
        check("mrst_out", cmd_out, 80'd0);
        check("mrst_empty", 80'(fifo_empty), 80'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("mrst_no_issue", 80'(write_cmd), 80'd0);
            check("mrst_count_hold", 80'(fifo_count), 80'd0);
        end

        // Busy held for 20 cycles with one command queued
        ctrl_busy = 1'b1;
        in_valid  = 2'b01;
        ch0_cmd   = mk(3'd3, 16'h0777);
        tick();
        in_valid = 2'b00;
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        check("stall_no_wc", 80'(write_cmd), 80'd0);
        check("stall_count", 80'(fifo_count), 80'd1);
`ifdef SPRITE_SEQ_STATS_EN
        check("stat_stall20", 80'(stall_cnt), 80'd20);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("clr_stall", 80'(stall_cnt), 80'd0);
        check("clr_nop", 80'(nop_cnt), 80'd0);
        check("clr_issued", 80'(issued_cnt), 80'd0);
`endif
        ctrl_busy = 1'b0;
        tick();
        check("stall_release_wc", 80'(write_cmd), 80'd1);
        check("stall_release_out", cmd_out, mk(3'd3, 16'h0777));
        check("stall_release_empty", 80'(fifo_empty), 80'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
